alib_rle_golomb_encoder: RTL and testbench
==========================================

ALIB_RLE_GOLOMB_ENCODER -- requirements
Module: alib_rle_golomb_encoder

Interface
REQ-001 The block SHALL have parameter WIDTH_CODE, default 16, width of the emitted code word; legal values are >= 15.
REQ-002 The block SHALL have a single clock and an asynchronous active-high reset: i_clk input 1 (rising-edge clock); i_rst input 1 (async, active-high).
REQ-003 i_data  input  7  unsigned sample value.
REQ-004 i_last  input  1  marks the final sample of a block; qualified by i_valid.
REQ-005 i_valid  input  1  sample present.
REQ-006 o_ready  output  1  block accepts a sample; transfer when i_valid & o_ready.
REQ-007 o_wr_data  output  WIDTH_CODE  code right-aligned; bits above the code length are 0.
REQ-008 o_wr_data_len  output  $clog2(WIDTH_CODE)+1  code length in bits (1..15).
REQ-009 o_wr_en  output  1  one-cycle write strobe to the downstream accumulator FIFO.
REQ-010 i_full  input  1  downstream FIFO full; no write is issued while it is high.

Function
REQ-011 Code: ue(v) SHALL be (v+1) in binary, length 2*floor(log2(v+1))+1; e.g. ue(0)=1/1, ue(2)=0x3/3, ue(127)=0x80/15.
REQ-012 FSM states SHALL be COUNT, EMIT_RUN, EMIT_LEVEL; o_ready = (state==COUNT).
REQ-013 In COUNT, an accepted zero sample without i_last SHALL increment the 7-bit run counter r; no output.
REQ-014 An accepted nonzero sample L SHALL latch pair (r, L), clear r, and go to EMIT_RUN.
REQ-015 An accepted zero sample that makes r reach 127 SHALL latch escape pair (127, 0), clear r, and go to EMIT_RUN.
REQ-016 EMIT_RUN: write ue(run), then go to EMIT_LEVEL; EMIT_LEVEL: write ue(level), then go to COUNT or to the pending EOB pair.
REQ-017 A write SHALL occur in an emit state exactly in a cycle with i_full==0; o_wr_en = emit_state & ~i_full; state, o_wr_data and o_wr_data_len SHALL hold while i_full==1.
REQ-018 o_wr_data/o_wr_data_len SHALL be valid in every emit-state cycle; o_wr_en SHALL be 0 in COUNT.
REQ-019 i_last: after any pair produced by that sample, the block SHALL emit EOB pair (t, 0), t = trailing zero count of the block (0..126), then return to COUNT with r=0.
REQ-020 i_last on a zero sample reaching r=127: escape (127,0) then EOB (0,0).
REQ-021 i_last on a zero sample with r<127 after increment: only EOB (r, 0).
REQ-022 Level 0 SHALL appear only in escape (run=127) or EOB (run<127) pairs.
REQ-023 Minimum latency: sample accepted at edge N -> run write at N+1, level write at N+2, o_ready high again at N+2 edge (no EOB, i_full low).
REQ-024 Throughput: one nonzero sample per 3 cycles; zero samples (non-terminal) one per cycle.

Reset
REQ-025 On i_rst high, asynchronously: state=COUNT, r=0, latched pair=0, EOB pending=0, o_wr_en=0, o_wr_data=0, o_wr_data_len=0; o_ready=1 from the first edge after release.
REQ-026 Reset asserted mid-emission SHALL abort the pending pair(s) with no further write.

Verification
REQ-027 Reset release, i_valid=0 -> o_ready=1, o_wr_en=0, outputs 0 for 10 cycles.
REQ-028 Samples 0,0,5 back-to-back, i_full=0 -> writes (0x0003,3) then (0x0006,5); o_ready low exactly 2 cycles.
REQ-029 Single sample 1 with i_last -> writes (0x1,1),(0x2,3),(0x1,1),(0x1,1).
REQ-030 127 zeros then sample 3 -> (0x80,15),(0x1,1),(0x1,1),(0x4,5); r=0 afterwards.
REQ-031 i_full held high 4 cycles in EMIT_RUN for sample 5 after no zeros -> o_wr_en=0 and (0x1,1) stable throughout; write on first cycle i_full=0, then (0x6,5).
REQ-032 i_rst pulsed during EMIT_LEVEL -> o_wr_en=0 immediately, no level write, next sample 2 -> (0x1,1),(0x3,3).

Source files
------------

// File: rtl/alib_rle_golomb_encoder_if.sv
// Sample-in / code-word-out bundle for the RLE + Exp-Golomb encoder.
// The master side drives samples and FIFO full; the slave side is the encoder.
interface alib_rle_golomb_encoder_if #(
   parameter int WIDTH_CODE = 16
) ();
   localparam int LEN_W = $clog2(WIDTH_CODE) + 1;

   logic [6:0]            i_data;
   logic                  i_last;
   logic                  i_valid;
   logic                  o_ready;
   logic [WIDTH_CODE-1:0] o_wr_data;
   logic [LEN_W-1:0]      o_wr_data_len;
   logic                  o_wr_en;
   logic                  i_full;

   modport master (
      output i_data, i_last, i_valid, i_full,
      input  o_ready, o_wr_data, o_wr_data_len, o_wr_en
   );

   modport slave (
      input  i_data, i_last, i_valid, i_full,
      output o_ready, o_wr_data, o_wr_data_len, o_wr_en
   );
endinterface

// File: rtl/alib_rle_golomb_encoder.sv
// Zero-run / level encoder emitting ue(v) code words; run write 1 cycle and level write 2 cycles after accept.
// Backpressure: emit states stall with outputs held while i_full is high; o_ready only in COUNT.
module alib_rle_golomb_encoder #(
   parameter int WIDTH_CODE = 16
) (
   input  logic                        i_clk,
   input  logic                        i_rst,
   alib_rle_golomb_encoder_if.slave    bus
);
   localparam int LEN_W = $clog2(WIDTH_CODE) + 1;

   typedef enum logic [1:0] {
      COUNT,
      EMIT_RUN,
      EMIT_LEVEL
   } state_t;

   state_t     state;
   logic [6:0] run_cnt;
   logic [6:0] level_q;
   logic       eob_pend;

   logic [6:0] run_inc;
   logic [6:0] pair_run;
   logic [6:0] code_src;
   logic [7:0] code_nxt;
   logic [3:0] len_nxt;
   logic       accept;
   logic       is_zero;

   function automatic logic [7:0] ue_code(input logic [6:0] v);
      return {1'b0, v} + 8'd1;
   endfunction

   // Length is 2*msb(v+1)+1, i.e. the msb index with a 1 appended.
   function automatic logic [3:0] ue_len(input logic [6:0] v);
      logic [7:0] c;
      logic [2:0] msb;
      c   = {1'b0, v} + 8'd1;
      msb = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (c[i]) msb = 3'(i);
      end
      return {msb, 1'b1};
   endfunction

   assign accept   = bus.i_valid && (state == COUNT);
   assign is_zero  = (bus.i_data == 7'd0);
   assign run_inc  = run_cnt + 7'd1;
   // Zero samples that leave COUNT (escape or terminal) carry the incremented run.
   assign pair_run = is_zero ? run_inc : run_cnt;

   always_comb begin
      code_src = 7'd0;
      case (state)
         COUNT:    code_src = pair_run;
         EMIT_RUN: code_src = level_q;
         default:  code_src = 7'd0;
      endcase
   end

   assign code_nxt = ue_code(code_src);
   assign len_nxt  = ue_len(code_src);

   assign bus.o_ready = (state == COUNT);
   assign bus.o_wr_en = (state != COUNT) && !bus.i_full;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state             <= COUNT;
         run_cnt           <= 7'd0;
         level_q           <= 7'd0;
         eob_pend          <= 1'b0;
         bus.o_wr_data     <= '0;
         bus.o_wr_data_len <= '0;
      end else begin
         case (state)
            COUNT: begin
               if (accept) begin
                  if (!is_zero || run_inc == 7'd127 || bus.i_last) begin
                     level_q           <= bus.i_data;
                     run_cnt           <= 7'd0;
                     // A terminal zero below 127 is itself the EOB pair.
                     eob_pend          <= bus.i_last && (!is_zero || run_inc == 7'd127);
                     bus.o_wr_data     <= WIDTH_CODE'(code_nxt);
                     bus.o_wr_data_len <= LEN_W'(len_nxt);
                     state             <= EMIT_RUN;
                  end else begin
                     run_cnt <= run_inc;
                  end
               end
            end
            EMIT_RUN: begin
               if (!bus.i_full) begin
                  bus.o_wr_data     <= WIDTH_CODE'(code_nxt);
                  bus.o_wr_data_len <= LEN_W'(len_nxt);
                  state             <= EMIT_LEVEL;
               end
            end
            EMIT_LEVEL: begin
               if (!bus.i_full) begin
                  if (eob_pend) begin
                     // Trailing zeros are always 0 here, so the EOB pair is (0,0).
                     eob_pend          <= 1'b0;
                     level_q           <= 7'd0;
                     bus.o_wr_data     <= WIDTH_CODE'(code_nxt);
                     bus.o_wr_data_len <= LEN_W'(len_nxt);
                     state             <= EMIT_RUN;
                  end else begin
                     bus.o_wr_data     <= '0;
                     bus.o_wr_data_len <= '0;
                     state             <= COUNT;
                  end
               end
            end
            default: state <= COUNT;
         endcase
      end
   end
endmodule

// File: tb/tb_alib_rle_golomb_encoder.sv
// Directed bench for the RLE + Exp-Golomb encoder: each task drives one scenario
// and compares captured writes against hand-computed code words.
module tb_alib_rle_golomb_encoder;
   localparam int W  = 16;
   localparam int LW = 5;
   localparam int PW = W + LW;

   logic clk;
   logic rst;
   int   tests = 0;
   int   fails = 0;

   alib_rle_golomb_encoder_if #(.WIDTH_CODE(W)) bus ();

   alib_rle_golomb_encoder #(.WIDTH_CODE(W)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [PW-1:0] wq [$];
   int            wcyc [$];
   int            accq [$];
   int            nc = 0;
   int            rdy_low = 0;

   always @(negedge clk) begin
      if (bus.o_wr_en === 1'b1) begin
         wq.push_back({bus.o_wr_data, bus.o_wr_data_len});
         wcyc.push_back(nc);
      end
      if (bus.i_valid === 1'b1 && bus.o_ready === 1'b1) accq.push_back(nc);
      if (bus.o_ready !== 1'b1) rdy_low++;
      nc++;
   end

   task automatic clear_log();
      wq.delete();
      wcyc.delete();
      accq.delete();
      rdy_low = 0;
   endtask

   task automatic send(input logic [6:0] d, input logic l);
      int n;
      n = 0;
      bus.i_data  = d;
      bus.i_last  = l;
      bus.i_valid = 1'b1;
      @(negedge clk);
      while (bus.o_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) begin
         tests++;
         fails++;
         $display("FAIL send_timeout got o_ready=%b exp 1", bus.o_ready);
      end
      @(posedge clk);
      #1;
      bus.i_valid = 1'b0;
      bus.i_last  = 1'b0;
      bus.i_data  = 7'd0;
   endtask

   task automatic drain();
      repeat (12) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      @(negedge clk);
      tests++;
      if ({bus.o_ready, bus.o_wr_en, bus.o_wr_data, bus.o_wr_data_len} !== {1'b1, 1'b0, 16'h0, 5'd0}) begin
         fails++;
         $display("FAIL reset_during got rdy=%b en=%b d=%h l=%0d exp 1 0 0 0",
                  bus.o_ready, bus.o_wr_en, bus.o_wr_data, bus.o_wr_data_len);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         tests++;
         if ({bus.o_ready, bus.o_wr_en, bus.o_wr_data, bus.o_wr_data_len} !== {1'b1, 1'b0, 16'h0, 5'd0}) begin
            fails++;
            $display("FAIL reset_idle[%0d] got rdy=%b en=%b d=%h l=%0d exp 1 0 0 0",
                     i, bus.o_ready, bus.o_wr_en, bus.o_wr_data, bus.o_wr_data_len);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_zero_run();
      logic [PW-1:0] exp [2];
      logic [PW-1:0] got;
      exp = '{{16'h0003, 5'd3}, {16'h0006, 5'd5}};
      clear_log();
      send(7'd0, 1'b0);
      send(7'd0, 1'b0);
      send(7'd5, 1'b0);
      drain();
      tests++;
      if (wq.size() !== 2) begin fails++; $display("FAIL zero_run_count got %0d exp 2", wq.size()); end
      for (int i = 0; i < 2; i++) begin
         got = (i < wq.size()) ? wq[i] : 'x;
         tests++;
         if (got !== exp[i]) begin fails++; $display("FAIL zero_run[%0d] got %h exp %h", i, got, exp[i]); end
      end
      tests++;
      if (rdy_low !== 2) begin fails++; $display("FAIL zero_run_ready_low got %0d exp 2", rdy_low); end
      tests++;
      if (accq.size() !== 3 || wcyc.size() !== 2) begin
         fails++;
         $display("FAIL zero_run_timing got acc=%0d wr=%0d exp 3 2", accq.size(), wcyc.size());
      end else if (accq[1] - accq[0] !== 1 || accq[2] - accq[1] !== 1 ||
                   wcyc[0] - accq[2] !== 1 || wcyc[1] - accq[2] !== 2) begin
         fails++;
         $display("FAIL zero_run_timing got acc %0d %0d %0d wr %0d %0d exp consecutive, +1, +2",
                  accq[0], accq[1], accq[2], wcyc[0], wcyc[1]);
      end
   endtask

   task automatic test_last_single();
      logic [PW-1:0] exp [4];
      logic [PW-1:0] got;
      exp = '{{16'h0001, 5'd1}, {16'h0002, 5'd3}, {16'h0001, 5'd1}, {16'h0001, 5'd1}};
      clear_log();
      send(7'd1, 1'b1);
      drain();
      tests++;
      if (wq.size() !== 4) begin fails++; $display("FAIL last_single_count got %0d exp 4", wq.size()); end
      for (int i = 0; i < 4; i++) begin
         got = (i < wq.size()) ? wq[i] : 'x;
         tests++;
         if (got !== exp[i]) begin fails++; $display("FAIL last_single[%0d] got %h exp %h", i, got, exp[i]); end
      end
   endtask

   task automatic test_escape();
      logic [PW-1:0] exp [6];
      logic [PW-1:0] got;
      exp = '{{16'h0080, 5'd15}, {16'h0001, 5'd1}, {16'h0001, 5'd1}, {16'h0004, 5'd5},
              {16'h0002, 5'd3}, {16'h0005, 5'd5}};
      clear_log();
      for (int i = 0; i < 127; i++) send(7'd0, 1'b0);
      send(7'd3, 1'b0);
      send(7'd0, 1'b0);
      send(7'd4, 1'b0);
      drain();
      tests++;
      if (wq.size() !== 6) begin fails++; $display("FAIL escape_count got %0d exp 6", wq.size()); end
      for (int i = 0; i < 6; i++) begin
         got = (i < wq.size()) ? wq[i] : 'x;
         tests++;
         if (got !== exp[i]) begin fails++; $display("FAIL escape[%0d] got %h exp %h", i, got, exp[i]); end
      end
      tests++;
      if (rdy_low !== 6) begin fails++; $display("FAIL escape_ready_low got %0d exp 6", rdy_low); end
   endtask

   task automatic test_last_zero();
      logic [PW-1:0] exp [2];
      logic [PW-1:0] got;
      exp = '{{16'h0004, 5'd5}, {16'h0001, 5'd1}};
      clear_log();
      send(7'd0, 1'b0);
      send(7'd0, 1'b0);
      send(7'd0, 1'b1);
      drain();
      tests++;
      if (wq.size() !== 2) begin fails++; $display("FAIL last_zero_count got %0d exp 2", wq.size()); end
      for (int i = 0; i < 2; i++) begin
         got = (i < wq.size()) ? wq[i] : 'x;
         tests++;
         if (got !== exp[i]) begin fails++; $display("FAIL last_zero[%0d] got %h exp %h", i, got, exp[i]); end
      end
   endtask

   task automatic test_last_escape();
      logic [PW-1:0] exp [4];
      logic [PW-1:0] got;
      exp = '{{16'h0080, 5'd15}, {16'h0001, 5'd1}, {16'h0001, 5'd1}, {16'h0001, 5'd1}};
      clear_log();
      for (int i = 0; i < 126; i++) send(7'd0, 1'b0);
      send(7'd0, 1'b1);
      drain();
      tests++;
      if (wq.size() !== 4) begin fails++; $display("FAIL last_escape_count got %0d exp 4", wq.size()); end
      for (int i = 0; i < 4; i++) begin
         got = (i < wq.size()) ? wq[i] : 'x;
         tests++;
         if (got !== exp[i]) begin fails++; $display("FAIL last_escape[%0d] got %h exp %h", i, got, exp[i]); end
      end
   endtask

   task automatic test_full_stall();
      logic [PW-1:0] exp [2];
      logic [PW-1:0] got;
      exp = '{{16'h0001, 5'd1}, {16'h0006, 5'd5}};
      clear_log();
      bus.i_full = 1'b1;
      send(7'd5, 1'b0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         tests++;
         if ({bus.o_wr_en, bus.o_wr_data, bus.o_wr_data_len} !== {1'b0, 16'h0001, 5'd1}) begin
            fails++;
            $display("FAIL full_hold[%0d] got en=%b d=%h l=%0d exp 0 0001 1",
                     i, bus.o_wr_en, bus.o_wr_data, bus.o_wr_data_len);
         end
         @(posedge clk);
         #1;
      end
      bus.i_full = 1'b0;
      @(negedge clk);
      tests++;
      if ({bus.o_wr_en, bus.o_wr_data, bus.o_wr_data_len} !== {1'b1, 16'h0001, 5'd1}) begin
         fails++;
         $display("FAIL full_release got en=%b d=%h l=%0d exp 1 0001 1",
                  bus.o_wr_en, bus.o_wr_data, bus.o_wr_data_len);
      end
      drain();
      tests++;
      if (wq.size() !== 2) begin fails++; $display("FAIL full_count got %0d exp 2", wq.size()); end
      for (int i = 0; i < 2; i++) begin
         got = (i < wq.size()) ? wq[i] : 'x;
         tests++;
         if (got !== exp[i]) begin fails++; $display("FAIL full_writes[%0d] got %h exp %h", i, got, exp[i]); end
      end
   endtask

   task automatic test_reset_mid_emit();
      logic [PW-1:0] exp [3];
      logic [PW-1:0] got;
      exp = '{{16'h0001, 5'd1}, {16'h0001, 5'd1}, {16'h0003, 5'd3}};
      clear_log();
      send(7'd7, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      tests++;
      if ({bus.o_wr_en, bus.o_ready} !== 2'b01) begin
         fails++;
         $display("FAIL reset_mid_abort got en=%b rdy=%b exp 0 1", bus.o_wr_en, bus.o_ready);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      send(7'd2, 1'b0);
      drain();
      tests++;
      if (wq.size() !== 3) begin fails++; $display("FAIL reset_mid_count got %0d exp 3", wq.size()); end
      for (int i = 0; i < 3; i++) begin
         got = (i < wq.size()) ? wq[i] : 'x;
         tests++;
         if (got !== exp[i]) begin fails++; $display("FAIL reset_mid[%0d] got %h exp %h", i, got, exp[i]); end
      end
   endtask

   task automatic test_back_to_back();
      logic [PW-1:0] exp [4];
      logic [PW-1:0] got;
      exp = '{{16'h0001, 5'd1}, {16'h0004, 5'd5}, {16'h0001, 5'd1}, {16'h0007, 5'd5}};
      clear_log();
      send(7'd3, 1'b0);
      send(7'd6, 1'b0);
      drain();
      tests++;
      if (wq.size() !== 4) begin fails++; $display("FAIL b2b_count got %0d exp 4", wq.size()); end
      for (int i = 0; i < 4; i++) begin
         got = (i < wq.size()) ? wq[i] : 'x;
         tests++;
         if (got !== exp[i]) begin fails++; $display("FAIL b2b[%0d] got %h exp %h", i, got, exp[i]); end
      end
      tests++;
      if (accq.size() !== 2) begin
         fails++;
         $display("FAIL b2b_spacing got %0d accepts exp 2", accq.size());
      end else if (accq[1] - accq[0] !== 3) begin
         fails++;
         $display("FAIL b2b_spacing got %0d cycles exp 3", accq[1] - accq[0]);
      end
   endtask

   initial begin
      rst         = 1'b1;
      bus.i_data  = 7'd0;
      bus.i_last  = 1'b0;
      bus.i_valid = 1'b0;
      bus.i_full  = 1'b0;
      @(posedge clk);
      #1;
      test_reset();
      test_zero_run();
      test_last_single();
      test_escape();
      test_last_zero();
      test_last_escape();
      test_full_stall();
      test_reset_mid_emit();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
